// File: rtl/nf2401_pkg.sv
// Shared definitions for the nF2401 receive controller: register map,
// status/event bit positions and the receive FSM encoding.
package nf2401_pkg;

   localparam logic [2:0] ADDR_RXDATA   = 3'd0;
   localparam logic [2:0] ADDR_STATUS   = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EVENT    = 3'd3;
   localparam logic [2:0] ADDR_CONTROL  = 3'd4;

   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;

   localparam int EV_DONE_BIT  = 0;
   localparam int EV_OVF_BIT   = 1;
   localparam int EV_SHORT_BIT = 2;

   localparam int CTRL_EN_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOW   = 2'd1,
      ST_HIGH  = 2'd2,
      ST_STORE = 2'd3
   } rx_state_t;

endpackage

// File: rtl/nf2401_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head reads 0x00 when empty.
module nf2401_rx_fifo #(
   parameter int DEPTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   import nf2401_pkg::*;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/nf2401_rx_ctrl.sv
// nF2401 ShockBurst receive controller: clocks payload bytes out of the radio
// on nf_clk1 into a byte FIFO and exposes them through an Avalon slave.
module nf2401_rx_ctrl
   import nf2401_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 25,
   parameter int CLK_DIV       = 25,
   parameter int FIFO_DEPTH    = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] address,
   input  logic       chipselect,
   input  logic       read_n,
   input  logic       write_n,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       irq,
   input  logic       nf_dr1,
   input  logic       nf_data,
   output logic       nf_clk1,
   output logic       nf_ce
);
   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int BYTE_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam int FAW    = $clog2(FIFO_DEPTH);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PAYLOAD_BYTES - 1);

   rx_state_t         state;
   logic [DIV_W-1:0]  div_cnt;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-1:0] byte_cnt;
   logic [7:0]        shift_reg;
   logic              dr1_s1, dr1_s2, data_s1, data_s2;
   logic              dr1_rise, busy, enable, overflow, stop;
   logic [2:0]        irq_mask, evt, ev_set, ev_clr;
   logic              rd_en, wr_en, rd_pop, fifo_push, ovf_set, ovf_clr;
   logic [7:0]        fifo_head, rd_mux;
   logic              fifo_full, fifo_empty;
   logic [FAW:0]      unused_fifo_count;
   logic              unused_wdata;

   assign unused_wdata = ^writedata[7:3];
   assign dr1_rise  = dr1_s1 & ~dr1_s2;
   assign busy      = (state != ST_IDLE);
   assign rd_en     = chipselect & ~read_n;
   assign wr_en     = chipselect & ~write_n;
   assign rd_pop    = rd_en & (address == ADDR_RXDATA);
   assign fifo_push = (state == ST_STORE) & enable;
   // Full FIFO is never empty, so only a real pop can make room.
   assign ovf_set   = fifo_push & fifo_full & ~rd_pop;
   assign ovf_clr   = wr_en & (address == ADDR_EVENT) & writedata[EV_OVF_BIT];
   assign ev_clr    = (wr_en && address == ADDR_EVENT) ? writedata[2:0] : 3'b000;
   // Leave the packet when disabled, or when dr1 drops before the last byte is stored.
   assign stop      = busy & (~enable |
                      (~dr1_s2 & ~((state == ST_STORE) && (byte_cnt == BYTE_LAST))));

   always_comb begin
      ev_set               = 3'b000;
      ev_set[EV_DONE_BIT]  = fifo_push & (byte_cnt == BYTE_LAST);
      ev_set[EV_OVF_BIT]   = ovf_set;
      ev_set[EV_SHORT_BIT] = stop & enable;
   end

   assign nf_ce = enable;
   assign irq   = |(evt & irq_mask);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dr1_s1  <= 1'b0;
         dr1_s2  <= 1'b0;
         data_s1 <= 1'b0;
         data_s2 <= 1'b0;
      end else begin
         dr1_s1  <= nf_dr1;
         dr1_s2  <= dr1_s1;
         data_s1 <= nf_data;
         data_s2 <= data_s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         nf_clk1  <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else if (stop) begin
         state   <= ST_IDLE;
         nf_clk1 <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (dr1_rise && enable) begin
               state    <= ST_LOW;
               nf_clk1  <= 1'b0;
               div_cnt  <= '0;
               bit_cnt  <= '0;
               byte_cnt <= '0;
            end
            ST_LOW: if (div_cnt == DIV_LAST) begin
               state   <= ST_HIGH;
               nf_clk1 <= 1'b1;
               div_cnt <= '0;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
            ST_HIGH: if (div_cnt == DIV_LAST) begin
               nf_clk1 <= 1'b0;
               div_cnt <= '0;
               if (bit_cnt == 3'd7) begin
                  state <= ST_STORE;
               end else begin
                  state   <= ST_LOW;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
            ST_STORE: begin
               bit_cnt <= '0;
               if (byte_cnt == BYTE_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  state    <= ST_LOW;
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Radio data is captured MSB-first on the cycle nf_clk1 rises.
   always_ff @(posedge clk) begin
      if (state == ST_LOW && div_cnt == DIV_LAST) shift_reg <= {shift_reg[6:0], data_s2};
   end

   always_comb begin
      rd_mux = 8'h00;
      case (address)
         ADDR_RXDATA:   rd_mux = fifo_head;
         ADDR_STATUS: begin
            rd_mux[STAT_EMPTY_BIT] = fifo_empty;
            rd_mux[STAT_FULL_BIT]  = fifo_full;
            rd_mux[STAT_BUSY_BIT]  = busy;
            rd_mux[STAT_OVF_BIT]   = overflow;
         end
         ADDR_IRQ_MASK: rd_mux[2:0] = irq_mask;
         ADDR_EVENT:    rd_mux[2:0] = evt;
         ADDR_CONTROL:  rd_mux[CTRL_EN_BIT] = enable;
         default:       rd_mux = 8'h00;
      endcase
   end

   // Same-cycle set wins over a software clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         enable   <= 1'b0;
         evt      <= '0;
         overflow <= 1'b0;
         readdata <= '0;
      end else begin
         if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[2:0];
         if (wr_en && address == ADDR_CONTROL)  enable   <= writedata[CTRL_EN_BIT];
         evt      <= (evt & ~ev_clr) | ev_set;
         overflow <= (overflow & ~ovf_clr) | ovf_set;
         if (rd_en) readdata <= rd_mux;
      end
   end

   nf2401_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (shift_reg),
      .pop       (rd_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (unused_fifo_count)
   );

endmodule

// File: tb/tb_nf2401_rx_ctrl.sv
// Scoreboard bench for nf2401_rx_ctrl: a radio model clocks directed payloads
// in, register reads queue their expected value, a monitor compares readdata.
`timescale 1ns/1ps
module tb_nf2401_rx_ctrl;
   localparam int CLK_DIV = 25;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] address = '0;
   logic       chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
   logic [7:0] writedata = '0;
   logic [7:0] readdata;
   logic       irq, nf_dr1 = 1'b0, nf_data = 1'b0, nf_clk1, nf_ce;

   typedef struct {
      logic [7:0] exp;
      logic [2:0] addr;
   } rd_exp_t;

   rd_exp_t    sb_q[$];
   int         n_checks = 0, n_pass = 0;
   logic       rd_d = 1'b0;
   logic [7:0] pkt [32];
   int         pulses, bad_hi, bad_lo, tout = 0;

   always #5 clk = ~clk;

   nf2401_rx_ctrl #(.PAYLOAD_BYTES(25), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq(irq), .nf_dr1(nf_dr1), .nf_data(nf_data), .nf_clk1(nf_clk1), .nf_ce(nf_ce)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // readdata is valid on the cycle after a read strobe.
   always @(posedge clk) rd_d <= chipselect & ~read_n;
   always @(negedge clk) begin
      if (rd_d) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL read_unexpected: got 0x%0h, expected no read", readdata);
         end else begin
            rd_exp_t e;
            e = sb_q.pop_front();
            if (readdata === e.exp) n_pass++;
            else $display("FAIL read_addr%0d: got 0x%0h, expected 0x%0h", e.addr, readdata, e.exp);
         end
      end
   end

   task automatic bus_read(input logic [2:0] a, input logic [7:0] exp);
      @(negedge clk);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      sb_q.push_back('{exp: exp, addr: a});
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic wait_level(input logic lvl, output int w);
      w = 0;
      while (nf_clk1 !== lvl && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (nf_clk1 !== lvl) tout++;
   endtask

   // Radio model: presents pkt[] MSB-first, one bit per nf_clk1 pulse, then drops dr1.
   task automatic radio_send(input int nbits, input int pop_byte, input logic [7:0] pop_exp);
      int w;
      pulses = 0; bad_hi = 0; bad_lo = 0; tout = 0;
      @(negedge clk);
      nf_data = pkt[0][7];
      nf_dr1  = 1'b1;
      for (int b = 0; b < nbits; b++) begin
         wait_level(1'b1, w);
         if (tout != 0) break;
         if (b % 8 != 0 && w != CLK_DIV) bad_lo++;
         pulses++;
         wait_level(1'b0, w);
         if (tout != 0) break;
         if (w != CLK_DIV) bad_hi++;
         if (b + 1 < nbits) nf_data = pkt[(b+1)/8][7-((b+1)%8)];
         if (b % 8 == 7 && b / 8 == pop_byte) begin
            address = 3'd0; chipselect = 1'b1; read_n = 1'b0;
            sb_q.push_back('{exp: pop_exp, addr: 3'd0});
            @(negedge clk);
            chipselect = 1'b0; read_n = 1'b1;
         end
      end
      nf_dr1 = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_readdata", readdata, 0);
      check("rst_irq", irq, 0);
      check("rst_nf_ce", nf_ce, 0);
      check("rst_nf_clk1", nf_clk1, 0);
      reset_n = 1'b1;
      bus_read(3'd1, 8'h01);
      bus_read(3'd3, 8'h00);
      bus_read(3'd2, 8'h00);
      bus_read(3'd4, 8'h00);
      bus_read(3'd5, 8'h00);
      bus_write(3'd2, 8'h01);
      bus_write(3'd4, 8'hFF);
      bus_read(3'd2, 8'h01);
      bus_read(3'd4, 8'h01);
      check("nf_ce_on", nf_ce, 1);

      // Full packet 0x00..0x18
      for (int i = 0; i < 25; i++) pkt[i] = 8'(i);
      radio_send(200, -1, 8'h00);
      repeat (4) @(negedge clk);
      check("p1_pulses", pulses, 200);
      check("p1_bad_high_width", bad_hi, 0);
      check("p1_bad_low_width", bad_lo, 0);
      check("p1_timeout", tout, 0);
      check("p1_irq_set", irq, 1);
      bus_read(3'd3, 8'h01);
      bus_read(3'd1, 8'h00);
      bus_write(3'd3, 8'h01);
      check("irq_cleared", irq, 0);
      bus_read(3'd3, 8'h00);

      // Second packet without reads overflows the 32-byte FIFO
      for (int i = 0; i < 25; i++) pkt[i] = 8'(8'h19 + i);
      radio_send(200, -1, 8'h00);
      repeat (4) @(negedge clk);
      check("p2_pulses", pulses, 200);
      check("p2_timeout", tout, 0);
      bus_read(3'd1, 8'h0A);
      bus_read(3'd3, 8'h03);
      for (int i = 0; i < 32; i++) bus_read(3'd0, 8'(i));
      bus_read(3'd1, 8'h09);
      bus_read(3'd0, 8'h00);
      bus_read(3'd1, 8'h09);
      bus_write(3'd3, 8'h07);
      bus_read(3'd1, 8'h01);
      bus_read(3'd3, 8'h00);

      // Short packet: 3 bytes plus 4 bits
      for (int i = 0; i < 25; i++) pkt[i] = 8'(8'hA0 + i);
      radio_send(28, -1, 8'h00);
      repeat (6) @(negedge clk);
      check("short_nf_clk1", nf_clk1, 0);
      check("short_timeout", tout, 0);
      bus_read(3'd3, 8'h04);
      bus_read(3'd1, 8'h00);
      bus_read(3'd0, 8'hA0);
      bus_read(3'd0, 8'hA1);
      bus_read(3'd0, 8'hA2);
      bus_read(3'd1, 8'h01);
      bus_write(3'd3, 8'h07);

      // Fill to exactly 32, then pop in the same cycle as a STORE
      for (int i = 0; i < 25; i++) pkt[i] = 8'(8'h40 + i);
      radio_send(200, -1, 8'h00);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 25; i++) pkt[i] = 8'(8'h80 + i);
      radio_send(58, -1, 8'h00);
      repeat (6) @(negedge clk);
      bus_read(3'd1, 8'h02);
      bus_write(3'd3, 8'h07);
      pkt[0] = 8'hC5; pkt[1] = 8'hFF;
      radio_send(10, 0, 8'h40);
      repeat (6) @(negedge clk);
      check("store_pop_timeout", tout, 0);
      bus_read(3'd1, 8'h02);
      bus_read(3'd3, 8'h04);
      for (int i = 1; i < 25; i++) bus_read(3'd0, 8'(8'h40 + i));
      for (int i = 0; i < 7; i++) bus_read(3'd0, 8'(8'h80 + i));
      bus_read(3'd0, 8'hC5);
      bus_read(3'd1, 8'h01);
      bus_write(3'd3, 8'h07);

      // Enable cleared mid-packet
      @(negedge clk);
      nf_data = 1'b1; nf_dr1 = 1'b1;
      repeat (40) @(negedge clk);
      check("en_mid_clk1_high", nf_clk1, 1);
      bus_write(3'd4, 8'h00);
      @(negedge clk);
      check("en_off_nf_clk1", nf_clk1, 0);
      check("en_off_nf_ce", nf_ce, 0);
      bus_read(3'd1, 8'h01);
      bus_read(3'd3, 8'h00);
      nf_dr1 = 1'b0;

      // Reset pulsed mid-packet after one byte has been stored
      bus_write(3'd4, 8'h01);
      bus_write(3'd2, 8'h07);
      @(negedge clk);
      nf_dr1 = 1'b1;
      repeat (520) @(negedge clk);
      bus_read(3'd1, 8'h04);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_readdata", readdata, 0);
      check("rst_mid_nf_clk1", nf_clk1, 0);
      check("rst_mid_nf_ce", nf_ce, 0);
      check("rst_mid_irq", irq, 0);
      nf_dr1 = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(3'd1, 8'h01);
      bus_read(3'd3, 8'h00);
      bus_read(3'd2, 8'h00);
      bus_read(3'd4, 8'h00);
      bus_read(3'd0, 8'h00);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nf2401_rx_ctrl.md
NF2401_RX_CTRL -- requirements
Module: nf2401_rx_ctrl

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 25: payload bytes clocked out per packet (1..32).
REQ-002 SHALL have parameter CLK_DIV, default 25: clk cycles per nf_clk1 half-period (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 32: receive FIFO depth in bytes (power of 2).
REQ-004 SHALL have port clk, input, 1: the block's one clock.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports address (input, 3), chipselect (input, 1), read_n (input, 1), write_n (input, 1), writedata (input, 8), readdata (output, 8): Avalon slave, readdata registered.
REQ-007 SHALL have port irq, output, 1: level interrupt, high while (event & irq_mask) is nonzero.
REQ-008 SHALL have ports nf_dr1 (input, 1) and nf_data (input, 1): radio data-ready and serial data, both asynchronous.
REQ-009 SHALL have ports nf_clk1 (output, 1) and nf_ce (output, 1): radio shift clock and chip enable.

Function
REQ-010 SHALL pass nf_dr1 and nf_data through two clk flops each and SHALL detect a dr1 rising edge as (sync1 & ~sync2).
REQ-011 SHALL use a register map: 0 RX data (read pops FIFO); 1 status {3:overflow, 2:busy, 1:full, 0:empty}; 2 irq_mask[2:0]; 3 event[2:0]; 4 control {0:enable}.
REQ-012 SHALL return readdata one clk after the read strobe, with unused bits 0 and unmapped addresses reading 0.
REQ-013 SHALL drive nf_ce equal to control.enable.
REQ-014 SHALL use FSM states IDLE, LOW, HIGH and STORE.
REQ-015 IDLE -> LOW on a dr1 rising edge while enable=1 and not busy; the bit and byte counters clear.
REQ-016 LOW holds nf_clk1=0 for CLK_DIV cycles, then -> HIGH.
REQ-017 On entry to HIGH the block SHALL sample synchronized nf_data MSB-first into a shift register; HIGH holds nf_clk1=1 for CLK_DIV cycles.
REQ-018 HIGH -> LOW after bits 0..6 and -> STORE after bit 7.
REQ-019 STORE SHALL last 1 cycle, push the byte, then -> LOW, or -> IDLE after byte PAYLOAD_BYTES-1 with event[0] (packet done) set.
REQ-020 SHALL make busy=1 in every state except IDLE.
REQ-021 If synchronized dr1 falls before STORE of the last byte, the block SHALL -> IDLE next cycle, discard any partial byte, set event[2] (short packet) and keep bytes already pushed.
REQ-022 If enable is cleared mid-packet, the block SHALL -> IDLE next cycle with nf_clk1=0 and set no event.
REQ-023 A push while the FIFO is full SHALL drop the byte and set status.overflow and event[1] (both sticky).
REQ-024 A pop while the FIFO is empty SHALL return 0x00 and leave the pointers unchanged.
REQ-025 A simultaneous push and pop SHALL both take effect, leaving the count unchanged (full-FIFO case included).
REQ-026 A write to address 3 SHALL clear event bits where writedata=1 and clear status.overflow if bit1=1; the same-cycle set SHALL win over the clear.
REQ-027 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with the count kept at log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 On reset_n low the block SHALL immediately drive: FSM IDLE, nf_clk1=0, nf_ce=0, readdata=0, irq=0, irq_mask=0, event=0, control=0, overflow=0, FIFO empty, synchronizers 0.
REQ-029 Reset asserted mid-packet SHALL discard all FIFO contents and set no event.

Structure
REQ-030 SHALL place register address constants, status/event bit indices and the FSM state encoding in shared package nf2401_pkg.
REQ-031 SHALL implement the FIFO as sub-module nf2401_rx_fifo (sync, first-word-fall-through, full/empty/count outputs).

Verification
REQ-032 Enable=1, dr1 rise, model sends 25 bytes 0x00..0x18 -> 200 nf_clk1 pulses, each half-period 25 clk; FIFO reads return 0x00..0x18; event[0]=1.
REQ-033 irq_mask=0x1, packet completes -> irq=1; write 0x1 to address 3 -> irq=0 on the next cycle.
REQ-034 Two packets without reads (50 bytes, depth 32) -> 32 bytes kept, overflow=1, event[1]=1; reads return the first 32 bytes in order.
REQ-035 dr1 drops after 3 bytes plus 4 bits -> IDLE, FIFO count=3, event[2]=1, nf_clk1=0.
REQ-036 reset_n pulsed low mid-packet -> all outputs at reset values immediately; status reads 0x01.
REQ-037 Read address 0 with the FIFO empty -> 0x00, status unchanged; a pop coinciding with a STORE into a full FIFO -> count stays 32, no overflow.
